// File: rtl/rom_sequencer.sv
// rom_sequencer: walks a 4-word ROM from first_addr to last_addr, wrapping at
// the top address. Each word is offered downstream with a valid/ready handshake.
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : begin a run; only sampled while idle
//   first_addr, last_addr : run bounds, captured when start is accepted
//   addr                  : registered ROM address
//   rom_data              : combinational ROM word for addr
//   out_data, out_valid   : captured word and its valid flag
//   out_ready             : consumer accepts the word when high with out_valid
//   busy                  : high whenever not idle
//   done                  : one-cycle pulse after the final word transfers
//   count                 : words transferred in the current or last run
module rom_sequencer #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                xfer;
  logic                at_last;

  // A transfer is only possible while a word is being presented.
  assign xfer    = (state_q == S_PRESENT) && out_ready;
  assign at_last = (addr_q == last_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH;
      S_FETCH:   state_d = S_PRESENT;
      S_PRESENT: if (xfer) state_d = at_last ? S_IDLE : S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    addr_d  = addr_q;
    last_d  = last_q;
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = first_addr;
          last_d  = last_addr;
          count_d = '0;
        end
      end
      S_FETCH: begin
        // One cycle has elapsed since addr changed, so the ROM word is settled.
        data_d  = rom_data;
        valid_d = 1'b1;
      end
      S_PRESENT: begin
        if (xfer) begin
          count_d = CNT_W'(count_q + 1'b1);
          valid_d = 1'b0;
          if (at_last) begin
            done_d = 1'b1;
          end else begin
            // Natural overflow gives the wrap from the top address back to 0.
            addr_d = ADDR_W'(addr_q + 1'b1);
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      last_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      last_q  <= last_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign addr      = addr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;

endmodule

// File: tb/tb_rom_sequencer.sv
// tb_rom_sequencer: directed and random runs of rom_sequencer, checked every
// cycle against a run-queue reference model plus literal expected sequences.
module tb_rom_sequencer;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 3;
  localparam int          DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;

  logic [DATA_W-1:0] rom [DEPTH];

  int n_cmp     = 0;
  int n_err     = 0;
  int done_seen = 0;
  int xd[$];
  int xa[$];

  // Reference model: the run is a queue of addresses still to deliver.
  bit m_busy, m_fetch, m_valid, m_done;
  int m_addr, m_data, m_count;
  int m_run[$];

  always #5 clk = ~clk;

  assign rom_data = rom[addr];

  rom_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .addr       (addr),
    .rom_data   (rom_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // exp holds the expected sequence as hex nibbles, first element leftmost.
  task automatic check_seq(input string name, input int got[$], input int n, input int exp);
    check({name, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      check(name, got[i], (exp >> (4 * (n - 1 - i))) & 15);
    end
  endtask

  task automatic model_step();
    int n;
    bit nd;
    nd = 1'b0;
    if (rst) begin
      m_busy = 0; m_fetch = 0; m_valid = 0; m_done = 0;
      m_addr = 0; m_data = 0; m_count = 0;
      m_run.delete();
    end else begin
      if (!m_busy) begin
        if (start) begin
          n = ((int'(last_addr) - int'(first_addr) + DEPTH) % DEPTH) + 1;
          m_run.delete();
          for (int i = 0; i < n; i++) m_run.push_back((int'(first_addr) + i) % DEPTH);
          m_addr  = m_run[0];
          m_count = 0;
          m_busy  = 1;
          m_fetch = 1;
        end
      end else if (m_fetch) begin
        m_fetch = 0;
        m_valid = 1;
        m_data  = int'(rom[m_addr]);
      end else if (m_valid && out_ready) begin
        m_valid = 0;
        m_count++;
        void'(m_run.pop_front());
        if (m_run.size() == 0) begin
          m_busy = 0;
          nd     = 1'b1;
        end else begin
          m_addr  = m_run[0];
          m_fetch = 1;
        end
      end
      m_done = nd;
    end
  endtask

  // Transfer monitor and model advance on every edge.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (!rst && out_valid === 1'b1 && out_ready) begin
        xd.push_back(int'(out_data));
        xa.push_back(int'(addr));
      end
      model_step();
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("addr",      int'(addr),      m_addr);
      check("out_data",  int'(out_data),  m_data);
      check("out_valid", int'(out_valid), int'(m_valid));
      check("busy",      int'(busy),      int'(m_busy));
      check("done",      int'(done),      int'(m_done));
      check("count",     int'(count),     m_count);
      if (done) done_seen++;
    end
  end

  task automatic start_run(input int f, input int l, input bit sync);
    if (sync) @(negedge clk);
    first_addr = ADDR_W'(f);
    last_addr  = ADDR_W'(l);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    first_addr = ADDR_W'($urandom);
    last_addr  = ADDR_W'($urandom);
  endtask

  task automatic wait_done(input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check("done_wait", int'(found), 1);
  endtask

  task automatic clear_log();
    xd.delete();
    xa.delete();
    done_seen = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    first_addr = '0; last_addr = '0;
    rom[0] = 3'b101; rom[1] = 3'b010; rom[2] = 3'b111; rom[3] = 3'b001;

    repeat (2) @(negedge clk);
    check("rst_addr",  int'(addr),      0);
    check("rst_data",  int'(out_data),  0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy",  int'(busy),      0);
    check("rst_done",  int'(done),      0);
    check("rst_count", int'(count),     0);

    // Full sweep, started on the first edge after reset release.
    rst = 1'b0;
    out_ready = 1'b1;
    clear_log();
    start_run(0, 3, 1'b0);
    wait_done(40);
    @(negedge clk);
    check_seq("sweep_data", xd, 4, 'h5271);
    check_seq("sweep_addr", xa, 4, 'h0123);
    check("sweep_count", int'(count), 4);
    check("sweep_done",  done_seen, 1);

    // Wrap-around run.
    clear_log();
    start_run(3, 1, 1'b1);
    wait_done(40);
    @(negedge clk);
    check_seq("wrap_data", xd, 3, 'h152);
    check_seq("wrap_addr", xa, 3, 'h301);
    check("wrap_count", int'(count), 3);
    check("wrap_done",  done_seen, 1);

    // Single word with backpressure.
    out_ready = 1'b0;
    clear_log();
    start_run(2, 2, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", int'(out_valid), 1);
      check("hold_data",  int'(out_data),  7);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_done(20);
    @(negedge clk);
    check_seq("single_data", xd, 1, 'h7);
    check("single_count", int'(count), 1);
    check("single_done",  done_seen, 1);

    // Start pulsed again mid-run is ignored.
    clear_log();
    start_run(0, 1, 1'b1);
    first_addr = 2'd2; last_addr = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(40);
    repeat (4) @(negedge clk);
    check_seq("ignore_data", xd, 2, 'h52);
    check_seq("ignore_addr", xa, 2, 'h01);
    check("ignore_busy", int'(busy), 0);
    check("ignore_done", done_seen, 1);

    // Start in the done-pulse cycle is accepted.
    clear_log();
    start_run(1, 1, 1'b1);
    wait_done(20);
    start_run(3, 0, 1'b0);
    wait_done(40);
    @(negedge clk);
    check_seq("b2b_data", xd, 3, 'h215);
    check("b2b_count", int'(count), 2);
    check("b2b_done",  done_seen, 2);

    // Reset between edges while a word is presented.
    out_ready = 1'b0;
    clear_log();
    start_run(1, 2, 1'b1);
    @(negedge clk);
    check("pre_rst_valid", int'(out_valid), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_addr",  int'(addr),      0);
    check("arst_data",  int'(out_data),  0);
    check("arst_valid", int'(out_valid), 0);
    check("arst_busy",  int'(busy),      0);
    check("arst_done",  int'(done),      0);
    check("arst_count", int'(count),     0);
    @(negedge clk);
    check("arst_no_done", done_seen, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    clear_log();
    start_run(2, 3, 1'b1);
    wait_done(40);
    @(negedge clk);
    check_seq("post_rst_data", xd, 2, 'h71);
    check("post_rst_count", int'(count), 2);
    check("post_rst_done",  done_seen, 1);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 79) == 0);
      start      = ($urandom_range(0, 3) == 0);
      first_addr = ADDR_W'($urandom);
      last_addr  = ADDR_W'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; out_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rom_sequencer.md
ROM_SEQUENCER -- requirements
Module: rom_sequencer

Interface
REQ-001 Parameter ADDR_W, default 2, address width; matches 4-word ROM depth.
REQ-002 Parameter DATA_W, default 3, ROM word width; bit order {D2,D1,D0}.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  begin a read run; sampled only in IDLE.
REQ-006 first_addr  input  ADDR_W  first ROM address of the run; sampled on accepted start.
REQ-007 last_addr  input  ADDR_W  final ROM address of the run; sampled on accepted start.
REQ-008 addr  output  ADDR_W  registered address driven to the ROM.
REQ-009 rom_data  input  DATA_W  combinational ROM output {D2,D1,D0} for addr.
REQ-010 out_data  output  DATA_W  captured ROM word for the downstream consumer.
REQ-011 out_valid  output  1  out_data holds an untransferred word.
REQ-012 out_ready  input  1  consumer accepts out_data when high with out_valid.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse after the final word transfers.
REQ-015 count  output  ADDR_W+1  words transferred in current/last run.

Function
REQ-016 FSM states: IDLE, FETCH, PRESENT; no other reachable states.
REQ-017 IDLE + start=1 at edge: addr<=first_addr, latch last_addr, count<=0, state->FETCH.
REQ-018 start while busy=1 is ignored; first_addr/last_addr changes mid-run have no effect.
REQ-019 FETCH lasts exactly one cycle (ROM settle); at its closing edge out_data<=rom_data, out_valid<=1, state->PRESENT.
REQ-020 PRESENT: out_data and out_valid held stable until out_ready=1 at an edge (transfer).
REQ-021 Transfer: count<=count+1, out_valid<=0 at that edge.
REQ-022 Transfer with addr != latched last: addr<=addr+1 modulo 2^ADDR_W, state->FETCH.
REQ-023 Transfer with addr == latched last: state->IDLE, done=1 for the following cycle only.
REQ-024 Wrap-around: last<first runs through max address to 0 (first=3,last=1 gives 3,0,1).
REQ-025 first==last yields exactly one word; full cycle (first=0,last=3) yields 4 words, count=4.
REQ-026 Latency: start at edge k -> addr valid after k; out_valid=1 after edge k+1.
REQ-027 Throughput with out_ready held high: one word per 2 cycles.
REQ-028 out_ready=1 while out_valid=0 has no effect.
REQ-029 start asserted in the done-pulse cycle (IDLE) is accepted normally.
REQ-030 count holds its final value in IDLE until the next accepted start.

Reset
REQ-031 rst=1 forces immediately, regardless of clk: state=IDLE, addr=0, out_data=0, out_valid=0, busy=0, done=0, count=0.
REQ-032 rst mid-run aborts the run; no done pulse; in-flight word discarded.
REQ-033 First edge after rst deasserts behaves as IDLE (start honoured).

Verification
REQ-034 Bench ROM model: addr 0..3 -> 3'b101, 3'b010, 3'b111, 3'b001.
REQ-035 first=0,last=3, out_ready=1 -> out_data 101,010,111,001 on successive valid cycles; done once; count=4.
REQ-036 first=3,last=1, out_ready=1 -> addr 3,0,1; out_data 001,101,010; count=3.
REQ-037 first=2,last=2, out_ready low 5 cycles then high -> out_valid held, out_data=111 stable, one transfer, done, count=1.
REQ-038 start pulsed again during run (first=0,last=1) -> ignored; exactly 2 words, no restart.
REQ-039 rst asserted mid-PRESENT between edges -> outputs zero before next edge; no done; new start runs cleanly.
